// File: rtl/sm_trace_uart_tx.sv
// Trace transmitter for sm_cpu: snapshots {data, instr, pc} on a strobe and
// sends it as a 13-byte packet (sync byte + 12 payload bytes) on a UART 8N1 line.
module sm_trace_uart_tx #(
    parameter int unsigned CLK_DIV   = 434,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trace_valid,
    input  logic [31:0] trace_pc,
    input  logic [31:0] trace_instr,
    input  logic [31:0] trace_data,
    output logic        uart_tx,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST_BYTE = 4'd12;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [3:0]  byte_cnt;
    logic [95:0] snapshot;
    logic [7:0]  cur_byte;
    logic        baud_done;

    // Byte 0 is the sync marker; bytes 1..12 walk the snapshot low byte first.
    function automatic logic [7:0] select_byte(input logic [3:0] k, input logic [95:0] snap);
        logic [6:0] base;
        base = {k - 4'd1, 3'b000};
        if (k == 4'd0)
            return SYNC_BYTE;
        return snap[base +: 8];
    endfunction

    assign cur_byte  = select_byte(byte_cnt, snapshot);
    assign baud_done = (baud_cnt == BAUD_LAST);

    // Snapshot is pure data: loaded only on an accepted strobe, never reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && trace_valid)
            snapshot <= {trace_data, trace_instr, trace_pc};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            drop_cnt <= 8'd0;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 4'd0;
        end else begin
            if (trace_valid && state != IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (trace_valid) begin
                        state    <= START;
                        busy     <= 1'b1;
                        uart_tx  <= 1'b0;
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
                        byte_cnt <= 4'd0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state    <= DATA;
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
                        uart_tx  <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= 16'd0;
                        if (bit_cnt == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            uart_tx <= cur_byte[bit_cnt + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= 16'd0;
                        if (byte_cnt == LAST_BYTE) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            // Next start bit follows immediately, no idle gap.
                            byte_cnt <= byte_cnt + 4'd1;
                            state    <= START;
                            uart_tx  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_trace_uart_tx.sv
// Directed bench for sm_trace_uart_tx at CLK_DIV=4: packet decode, timing,
// drop counting and saturation, back-to-back accept, reset mid-packet.
module tb_sm_trace_uart_tx;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trace_valid;
    logic [31:0] trace_pc, trace_instr, trace_data;
    logic        uart_tx, busy;
    logic [7:0]  drop_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int busy_total = 0;
    int low_total  = 0;
    int b0, l0;

    logic [7:0] pkt     [13];
    logic [7:0] exp_pkt [13];

    sm_trace_uart_tx #(.CLK_DIV(CLK_DIV), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trace_valid(trace_valid),
        .trace_pc   (trace_pc),
        .trace_instr(trace_instr),
        .trace_data (trace_data),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Cycle counters of busy-high and line-low, sampled before the edge updates.
    always @(posedge clk) begin
        if (busy === 1'b1)    busy_total <= busy_total + 1;
        if (uart_tx === 1'b0) low_total  <= low_total + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; valid is sampled at the next posedge.
    task automatic strobe(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] data);
        trace_pc    = pc;
        trace_instr = instr;
        trace_data  = data;
        trace_valid = 1'b1;
        @(negedge clk);
        trace_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int waited = 0;
        while (uart_tx !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("rx_start_bit", 32'(uart_tx), 32'd0);
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        check("rx_stop_bit", 32'(uart_tx), 32'd1);
    endtask

    task automatic recv_packet();
        for (int k = 0; k < 13; k++) recv_byte(pkt[k]);
    endtask

    task automatic expect_record(input string tag, input logic [31:0] pc,
                                 input logic [31:0] instr, input logic [31:0] data);
        logic [31:0] words [3];
        logic [7:0]  e;
        words[0] = pc;
        words[1] = instr;
        words[2] = data;
        for (int k = 0; k < 13; k++) begin
            if (k == 0) e = 8'hA5;
            else        e = words[(k - 1) / 4][((k - 1) % 4) * 8 +: 8];
            check($sformatf("%s_byte%0d", tag, k), 32'(pkt[k]), 32'(e));
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy !== 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        trace_valid = 1'b0;
        trace_pc    = '0;
        trace_instr = '0;
        trace_data  = '0;

        // 1. Reset values and quiet line
        repeat (3) @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        l0 = low_total;
        b0 = busy_total;
        repeat (100) @(negedge clk);
        check("idle_line_low_cycles", 32'(low_total - l0), 32'd0);
        check("idle_busy_cycles", 32'(busy_total - b0), 32'd0);

        // 2. Single record with hand-computed bytes
        check("pre_accept_tx", 32'(uart_tx), 32'd1);
        b0 = busy_total;
        strobe(32'h10, 32'h24020001, 32'h3);
        check("latency_start_bit", 32'(uart_tx), 32'd0);
        check("accept_busy", 32'(busy), 32'd1);
        exp_pkt = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                    8'h02, 8'h24, 8'h03, 8'h00, 8'h00, 8'h00};
        recv_packet();
        for (int k = 0; k < 13; k++)
            check($sformatf("t2_byte%0d", k), 32'(pkt[k]), 32'(exp_pkt[k]));
        wait_idle();
        check("busy_len_cycles", 32'(busy_total - b0), 32'd520);

        // 3. Drops at +5, +100 and the last stop-bit cycle; inputs scrambled after accept
        strobe(32'hDEADBEEF, 32'h8C220004, 32'h80000001);
        fork
            recv_packet();
            begin
                trace_pc    = 32'h11111111;
                trace_instr = 32'h22222222;
                trace_data  = 32'h33333333;
                repeat (4) @(negedge clk);
                trace_valid = 1'b1;
                @(negedge clk);
                trace_valid = 1'b0;
                repeat (94) @(negedge clk);
                trace_valid = 1'b1;
                @(negedge clk);
                trace_valid = 1'b0;
                repeat (419) @(negedge clk);
                trace_valid = 1'b1;
                @(negedge clk);
                trace_valid = 1'b0;
            end
        join
        check("t3_drop_cnt", 32'(drop_cnt), 32'd3);
        check("t3_busy_after", 32'(busy), 32'd0);
        expect_record("t3", 32'hDEADBEEF, 32'h8C220004, 32'h80000001);
        l0 = low_total;
        repeat (20) @(negedge clk);
        check("t3_no_second_packet", 32'(low_total - l0), 32'd0);

        // 4. Strobe on the first IDLE cycle is accepted after a 1-cycle gap
        strobe(32'h00000100, 32'hAC430008, 32'h0000CAFE);
        recv_packet();
        expect_record("t4a", 32'h00000100, 32'hAC430008, 32'h0000CAFE);
        @(negedge clk);
        check("t4_last_stop_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t4_gap_busy", 32'(busy), 32'd0);
        check("t4_gap_tx", 32'(uart_tx), 32'd1);
        strobe(32'h00000104, 32'h03E00008, 32'h12345678);
        check("t4_second_start", 32'(uart_tx), 32'd0);
        check("t4_second_busy", 32'(busy), 32'd1);
        check("t4_drop_cnt", 32'(drop_cnt), 32'd3);
        recv_packet();
        expect_record("t4b", 32'h00000104, 32'h03E00008, 32'h12345678);
        wait_idle();

        // 5. Reset during byte 5 (instr[7:0]=00), data bit 3
        strobe(32'h00000400, 32'h12345600, 32'h0F0F0F0F);
        repeat (217) @(negedge clk);
        check("t5_pre_reset_bit", 32'(uart_tx), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_reset_tx", 32'(uart_tx), 32'd1);
        check("t5_reset_busy", 32'(busy), 32'd0);
        check("t5_reset_drop", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        l0 = low_total;
        repeat (50) @(negedge clk);
        check("t5_no_resume", 32'(low_total - l0), 32'd0);
        strobe(32'h00000408, 32'hFFFFFFFF, 32'hA5A5005A);
        recv_packet();
        expect_record("t5", 32'h00000408, 32'hFFFFFFFF, 32'hA5A5005A);
        wait_idle();

        // 6. 300 strobes while busy saturate drop_cnt
        strobe(32'h0000000C, 32'h00000000, 32'h00000000);
        trace_valid = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 254) check("t6_drop_254", 32'(drop_cnt), 32'd254);
            if (i == 255) check("t6_drop_255", 32'(drop_cnt), 32'd255);
        end
        trace_valid = 1'b0;
        check("t6_drop_sat", 32'(drop_cnt), 32'd255);
        wait_idle();
        check("t6_drop_hold", 32'(drop_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
